// File: rtl/limber_gnrl_div_arb.sv
// limber_gnrl_div_arb: round-robin arbiter sharing one unsigned iterative divider, with sign fixup and divide-by-zero bypass
module limber_gnrl_div_arb #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_flush,
  input  logic [NREQ-1:0]    i_req_valid,
  output logic [NREQ-1:0]    o_req_ready,
  input  logic [NREQ*DW-1:0] i_req_dividend,
  input  logic [NREQ*DW-1:0] i_req_divisor,
  input  logic [NREQ-1:0]    i_req_signed,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [IDW-1:0]     o_rsp_id,
  output logic [DW-1:0]      o_rsp_quo,
  output logic [DW-1:0]      o_rsp_rem,
  output logic               o_rsp_dz,
  output logic [DW-1:0]      o_div_dividend,
  output logic [DW-1:0]      o_div_divisor,
  output logic               o_div_valid,
  output logic               o_div_clr,
  input  logic [DW-1:0]      i_div_quo,
  input  logic [DW-1:0]      i_div_rem,
  input  logic               i_div_valid
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  state_e         state_q;
  logic [IDW-1:0] ptr_q, id_q, rsp_id_q, gnt, cand;
  logic           gnt_v, sq_q, sr_q, rsp_valid_q, rsp_dz_q, div_valid_q, g_sa, g_sb;
  logic [DW-1:0]  rsp_quo_q, rsp_rem_q, div_dvd_q, div_dvs_q, g_dvd, g_dvs;
  // First valid requester after the last granted one wins
  always_comb begin
    gnt = '0;
    gnt_v = 1'b0;
    cand = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % NREQ);
      if (!gnt_v && i_req_valid[cand]) begin
        gnt = cand;
        gnt_v = 1'b1;
      end
    end
  end
  assign g_dvd = i_req_dividend[gnt*DW +: DW];
  assign g_dvs = i_req_divisor[gnt*DW +: DW];
  assign g_sa = i_req_signed[gnt] & g_dvd[DW-1];
  assign g_sb = i_req_signed[gnt] & g_dvs[DW-1];
  assign o_req_ready = (state_q == IDLE && !i_flush && gnt_v) ? NREQ'(1) << gnt : '0;
  assign o_div_clr = i_flush && (state_q == ISSUE || state_q == WAIT);
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_id = rsp_id_q;
  assign o_rsp_quo = rsp_quo_q;
  assign o_rsp_rem = rsp_rem_q;
  assign o_rsp_dz = rsp_dz_q;
  assign o_div_dividend = div_dvd_q;
  assign o_div_divisor = div_dvs_q;
  assign o_div_valid = div_valid_q;
  // Sequencer: grant, issue magnitudes, wait for done, hold response until accepted; flush wins everywhere
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q <= IDW'(NREQ - 1);
      id_q <= '0;
      sq_q <= 1'b0;
      sr_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q <= '0;
      rsp_quo_q <= '0;
      rsp_rem_q <= '0;
      rsp_dz_q <= 1'b0;
      div_dvd_q <= '0;
      div_dvs_q <= '0;
      div_valid_q <= 1'b0;
    end else begin
      div_valid_q <= 1'b0;
      if (i_flush) begin
        state_q <= IDLE;
        rsp_valid_q <= 1'b0;
        rsp_id_q <= '0;
        rsp_quo_q <= '0;
        rsp_rem_q <= '0;
        rsp_dz_q <= 1'b0;
        div_dvd_q <= '0;
        div_dvs_q <= '0;
      end else begin
        case (state_q)
          IDLE: if (gnt_v) begin
            ptr_q <= gnt;
            id_q <= gnt;
            sq_q <= g_sa ^ g_sb;
            sr_q <= g_sa;
            if (g_dvs == '0) begin
              state_q <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_id_q <= gnt;
              rsp_quo_q <= '1;
              rsp_rem_q <= g_dvd;
              rsp_dz_q <= 1'b1;
            end else begin
              state_q <= ISSUE;
              div_valid_q <= 1'b1;
              div_dvd_q <= g_sa ? -g_dvd : g_dvd;
              div_dvs_q <= g_sb ? -g_dvs : g_dvs;
            end
          end
          ISSUE: state_q <= WAIT;
          WAIT: if (i_div_valid) begin
            state_q <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_id_q <= id_q;
            rsp_quo_q <= sq_q ? -i_div_quo : i_div_quo;
            rsp_rem_q <= sr_q ? -i_div_rem : i_div_rem;
            rsp_dz_q <= 1'b0;
            div_dvd_q <= '0;
            div_dvs_q <= '0;
          end
          RESP: if (i_rsp_ready) begin
            state_q <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_id_q <= '0;
            rsp_quo_q <= '0;
            rsp_rem_q <= '0;
            rsp_dz_q <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_limber_gnrl_div_arb.sv
// tb_limber_gnrl_div_arb: directed and random traffic against an arithmetic reference model and a variable-latency divider
module tb_limber_gnrl_div_arb;
  localparam int NREQ = 4;
  localparam int DW = 32;
  localparam int IDW = 2;
  typedef struct {int id; logic [DW-1:0] a; logic [DW-1:0] b; bit s; int gcyc; int lat;} txn_t;
  logic i_clk = 1'b0, i_rst = 1'b1, i_flush = 1'b0, i_rsp_ready = 1'b0, i_div_valid = 1'b0;
  logic [NREQ-1:0] i_req_valid = '0, sg = '0, o_req_ready;
  logic [NREQ*DW-1:0] i_req_dividend, i_req_divisor;
  logic [DW-1:0] dvd [NREQ], dvs [NREQ];
  logic o_rsp_valid, o_rsp_dz, o_div_valid, o_div_clr;
  logic [IDW-1:0] o_rsp_id;
  logic [DW-1:0] o_rsp_quo, o_rsp_rem, o_div_dividend, o_div_divisor, i_div_quo = '0, i_div_rem = '0;
  int n_cmp = 0, n_err = 0, cyc = 0, mptr = NREQ - 1, lat_sel = 2, scnt = 0;
  bit busy_m = 0, prev_rv = 0, sbusy = 0, stray = 0;
  logic [DW-1:0] sa, sb;
  txn_t cur;
  int dgo [$];
  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign i_req_dividend[g*DW +: DW] = dvd[g];
    assign i_req_divisor[g*DW +: DW] = dvs[g];
  end
  always #5 i_clk = ~i_clk;
  limber_gnrl_div_arb #(.NREQ(NREQ), .DW(DW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_dividend(i_req_dividend), .i_req_divisor(i_req_divisor), .i_req_signed(sg),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_id(o_rsp_id),
    .o_rsp_quo(o_rsp_quo), .o_rsp_rem(o_rsp_rem), .o_rsp_dz(o_rsp_dz),
    .o_div_dividend(o_div_dividend), .o_div_divisor(o_div_divisor),
    .o_div_valid(o_div_valid), .o_div_clr(o_div_clr),
    .i_div_quo(i_div_quo), .i_div_rem(i_div_rem), .i_div_valid(i_div_valid)
  );
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic longint sx(logic [DW-1:0] v, bit s);
    return s ? longint'($signed(v)) : longint'(v);
  endfunction
  function automatic logic [DW-1:0] mag(logic [DW-1:0] v, bit s);
    longint x = sx(v, s);
    return DW'(x < 0 ? -x : x);
  endfunction
  function automatic void calc(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit s,
                               output logic [DW-1:0] q, output logic [DW-1:0] r, output bit z);
    longint x = sx(a, s), y = sx(b, s);
    z = (b == '0);
    q = '1;
    r = a;
    if (!z) begin
      q = DW'(x / y);
      r = DW'(x % y);
    end
  endfunction
  function automatic int winner(logic [NREQ-1:0] v, int p);
    for (int k = 1; k <= NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction
  function automatic logic [DW-1:0] rnd();
    case ($urandom % 6)
      0: return 32'h8000_0000;
      1: return '1;
      2: return $urandom_range(0, 20);
      3: return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction
  task automatic cycle();
    int w;
    logic [NREQ-1:0] er;
    logic [DW-1:0] eq, erm;
    bit ez;
    int el;
    #1;
    w = winner(i_req_valid, mptr);
    er = (!busy_m && !i_flush && w >= 0) ? NREQ'(1) << w : '0;
    chk("req_ready", o_req_ready, er);
    for (int k = 0; k < NREQ; k++) if (o_req_ready[k]) dgo.push_back(k);
    chk("div_clr", o_div_clr, i_flush && busy_m && !o_rsp_valid);
    chk("div_valid", o_div_valid, busy_m && cyc == cur.gcyc + 1 && cur.b != '0);
    if (!busy_m) begin
      chk("idle_outs", |{o_rsp_valid, o_div_valid, o_rsp_id, o_rsp_quo, o_rsp_rem, o_rsp_dz, o_div_dividend, o_div_divisor}, 0);
    end else begin
      calc(cur.a, cur.b, cur.s, eq, erm, ez);
      el = ez ? 1 : cur.lat + 2;
      if (!ez && !o_rsp_valid && cyc > cur.gcyc) begin
        chk("div_dividend", o_div_dividend, mag(cur.a, cur.s));
        chk("div_divisor", o_div_divisor, mag(cur.b, cur.s));
      end
      if (cyc - cur.gcyc == el) chk("rsp_on_time", o_rsp_valid, 1);
      if (o_rsp_valid) begin
        if (!prev_rv) chk("rsp_latency", cyc - cur.gcyc, el);
        chk("rsp_id", o_rsp_id, cur.id);
        chk("rsp_quo", o_rsp_quo, eq);
        chk("rsp_rem", o_rsp_rem, erm);
        chk("rsp_dz", o_rsp_dz, ez);
      end
    end
    prev_rv = o_rsp_valid;
    if (er != '0) begin
      busy_m = 1;
      cur = '{w, dvd[w], dvs[w], sg[w], cyc, lat_sel};
      mptr = w;
    end else if (i_flush) begin
      if (busy_m) stray = 1;
      busy_m = 0;
      sbusy = 0;
      prev_rv = 0;
    end else if (busy_m && o_rsp_valid && i_rsp_ready) begin
      busy_m = 0;
      prev_rv = 0;
    end
    @(posedge i_clk);
    #1;
    cyc++;
    i_div_valid = stray;
    if (stray) begin
      i_div_quo = $urandom;
      i_div_rem = $urandom;
    end
    stray = 0;
    if (sbusy) begin
      scnt--;
      if (scnt == 0) begin
        i_div_valid = 1'b1;
        i_div_quo = (sb == '0) ? '1 : sa / sb;
        i_div_rem = (sb == '0) ? sa : sa % sb;
        sbusy = 0;
      end
    end else if (o_div_valid) begin
      sbusy = 1;
      sa = o_div_dividend;
      sb = o_div_divisor;
      scnt = cur.lat;
    end
  endtask
  task automatic drain();
    i_req_valid = '0;
    i_rsp_ready = 1'b1;
    for (int i = 0; i < 200 && busy_m; i++) cycle();
    cycle();
    i_rsp_ready = 1'b0;
  endtask
  task automatic run_op(int r, logic [DW-1:0] a, logic [DW-1:0] b, bit s, int lat, int hold, logic [NREQ-1:0] bg);
    dvd[r] = a;
    dvs[r] = b;
    sg[r] = s;
    lat_sel = lat;
    i_rsp_ready = 1'b0;
    i_req_valid = NREQ'(1) << r;
    for (int i = 0; i < 20 && !busy_m; i++) cycle();
    i_req_valid = bg;
    dvd[r] = $urandom;
    dvs[r] = $urandom;
    for (int i = 0; i < 100 && busy_m && !o_rsp_valid; i++) cycle();
    repeat (hold) cycle();
    i_rsp_ready = 1'b1;
    cycle();
    i_rsp_ready = 1'b0;
  endtask
  initial begin
    int n2;
    for (int k = 0; k < NREQ; k++) begin
      dvd[k] = $urandom;
      dvs[k] = (k == 1) ? '0 : DW'($urandom_range(1, 1000));
      sg[k] = 1'($urandom);
    end
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    i_req_valid = '1;
    i_rsp_ready = 1'b1;
    lat_sel = 2;
    for (int i = 0; i < 200 && dgo.size() < 5; i++) cycle();
    for (int k = 0; k < 5; k++) chk("rr_order", k < dgo.size() ? dgo[k] : -1, k % NREQ);
    i_req_valid = 4'b1011;
    dgo.delete();
    repeat (60) cycle();
    n2 = 0;
    foreach (dgo[k]) if (dgo[k] == 2) n2++;
    chk("rr_skip_dropped", n2, 0);
    chk("rr_progress", dgo.size() >= 4, 1);
    drain();
    run_op(0, 100, 7, 0, 5, 0, '0);
    run_op(1, -7, 2, 1, 3, 0, '0);
    run_op(2, 7, -2, 1, 1, 0, '0);
    run_op(3, -7, -2, 1, 7, 0, '0);
    run_op(0, 32'h8000_0000, -1, 1, DW, 0, '0);
    run_op(2, 55, 0, 0, 4, 0, '0);
    run_op(3, 32'hFFFF_FFF0, 3, 0, 2, 0, '0);
    dgo.delete();
    run_op(1, 1000, 33, 0, 4, 10, 4'b0001);
    cycle();
    chk("bp_next_grant", dgo.size(), 2);
    drain();
    dgo.delete();
    dvd[1] = 12345;
    dvs[1] = 67;
    sg[1] = 1'b0;
    lat_sel = 30;
    i_req_valid = 4'b0010;
    for (int i = 0; i < 20 && !busy_m; i++) cycle();
    i_req_valid = '0;
    repeat (6) cycle();
    i_flush = 1'b1;
    cycle();
    i_flush = 1'b0;
    repeat (4) cycle();
    dgo.delete();
    dvd[0] = 90;
    dvs[0] = 9;
    dvd[2] = -90;
    dvs[2] = 4;
    sg = 4'b0100;
    lat_sel = 3;
    i_req_valid = 4'b0101;
    for (int i = 0; i < 20 && !busy_m; i++) cycle();
    chk("flush_keeps_ptr", dgo.size() > 0 ? dgo[0] : -1, 2);
    drain();
    for (int i = 0; i < 900; i++) begin
      for (int k = 0; k < NREQ; k++) begin
        if ($urandom % 4 == 0) begin
          i_req_valid[k] = ($urandom % 3 != 0);
          dvd[k] = rnd();
          dvs[k] = ($urandom % 6 == 0) ? '0 : rnd();
          sg[k] = 1'($urandom);
        end
      end
      i_rsp_ready = ($urandom % 3 != 0);
      i_flush = ($urandom % 50 == 0);
      lat_sel = ($urandom % 8 == 0) ? DW : $urandom_range(1, 6);
      cycle();
    end
    i_flush = 1'b0;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
